// File: rtl/tdm_frame_sequencer_if.sv
// Word-accept handshake between a word source and tdm_frame_sequencer.
// The source drives in_data/in_valid; the sequencer answers with in_ready.
interface tdm_frame_sequencer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/tdm_frame_sequencer.sv
// Turns one accepted 8-bit word into an 8-slot TDM frame (sel 0..7) plus an optional idle gap.
// Define TDM_PARITY_EN to append a ninth parity slot carrying the even parity of the word.
module tdm_frame_sequencer #(
    parameter int SLOT_CYCLES = 1,
    parameter int IDLE_GAP    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    tdm_frame_sequencer_if.slave         bus,
    output logic [7:0]                   word_out,
    output logic [2:0]                   sel,
    output logic                         slot_valid,
    output logic                         frame_start,
    output logic                         frame_end,
    output logic                         busy,
    output logic                         parity_bit,
    output logic                         parity_slot
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SLOT = 2'd1;
`ifdef TDM_PARITY_EN
    localparam logic [1:0] ST_PAR  = 2'd2;
`endif
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic [7:0] SLOT_LAST   = 8'(SLOT_CYCLES - 1);
    localparam logic [7:0] GAP_LAST    = 8'(IDLE_GAP - 1);
    localparam logic [1:0] AFTER_FRAME = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;

    logic [1:0] state;
    logic [7:0] cnt;
    logic       slot_last;

    assign slot_last = (cnt == SLOT_LAST);

    // NOTE: every register below uses non-blocking assignment so all of them sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 8'd0;
            word_out <= 8'd0;
            sel      <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        word_out <= bus.in_data;
                        sel      <= 3'd0;
                        cnt      <= 8'd0;
                        state    <= ST_SLOT;
                    end
                end
                ST_SLOT: begin
                    if (slot_last) begin
                        cnt <= 8'd0;
                        if (sel != 3'd7) begin
                            sel <= sel + 3'd1;
                        end else begin
`ifdef TDM_PARITY_EN
                            state <= ST_PAR;
`else
                            state <= AFTER_FRAME;
`endif
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`ifdef TDM_PARITY_EN
                ST_PAR: begin
                    if (slot_last) begin
                        cnt   <= 8'd0;
                        state <= AFTER_FRAME;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`endif
                ST_GAP: begin
                    // The gap reuses the slot counter, which is already zero on entry.
                    if (cnt == GAP_LAST) begin
                        cnt   <= 8'd0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TDM_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (state == ST_IDLE && bus.in_valid) begin
            parity_q <= ^bus.in_data;
        end
    end

    assign parity_bit  = parity_q;
    assign parity_slot = (state == ST_PAR);
    assign slot_valid  = (state == ST_SLOT) || (state == ST_PAR);
    assign frame_end   = (state == ST_PAR) && slot_last;
`else
    assign parity_bit  = 1'b0;
    assign parity_slot = 1'b0;
    assign slot_valid  = (state == ST_SLOT);
    assign frame_end   = (state == ST_SLOT) && (sel == 3'd7) && slot_last;
`endif

    // Strobes and handshake are pure decodes of the registered state, so they glitch-free follow it.
    assign bus.in_ready = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign frame_start  = (state == ST_SLOT) && (sel == 3'd0) && (cnt == 8'd0);

endmodule

// File: tb/tb_tdm_frame_sequencer.sv
// Scoreboard bench: two sequencers (1-cycle slots/no gap and 3-cycle slots/2-cycle gap) share one stimulus;
// each accept pushes the whole expected frame, cycle by cycle, and a negedge monitor pops and compares.
module tb_tdm_frame_sequencer;

    localparam int SC_A  = 1;
    localparam int GAP_A = 0;
    localparam int SC_B  = 3;
    localparam int GAP_B = 2;
`ifdef TDM_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct {
        logic       sv;
        logic [2:0] sel;
        logic [7:0] word;
        logic       fs;
        logic       fe;
        logic       ps;
        logic       pb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;

    logic [7:0] word_out    [2];
    logic [2:0] sel         [2];
    logic       slot_valid  [2];
    logic       frame_start [2];
    logic       frame_end   [2];
    logic       busy        [2];
    logic       parity_bit  [2];
    logic       parity_slot [2];
    logic       in_ready    [2];

    int checks = 0;
    int errors = 0;

    exp_t       sb [2][$];
    logic       exp_ready [2] = '{1'b1, 1'b1};
    logic [7:0] last_word [2] = '{8'd0, 8'd0};
    logic [2:0] last_sel  [2] = '{3'd0, 3'd0};
    logic       last_pb   [2] = '{1'b0, 1'b0};

    tdm_frame_sequencer_if bus_a ();
    tdm_frame_sequencer_if bus_b ();

    assign bus_a.in_data  = in_data;
    assign bus_a.in_valid = in_valid;
    assign bus_b.in_data  = in_data;
    assign bus_b.in_valid = in_valid;
    assign in_ready[0]    = bus_a.in_ready;
    assign in_ready[1]    = bus_b.in_ready;

    tdm_frame_sequencer #(.SLOT_CYCLES(SC_A), .IDLE_GAP(GAP_A)) u_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .word_out(word_out[0]), .sel(sel[0]), .slot_valid(slot_valid[0]),
        .frame_start(frame_start[0]), .frame_end(frame_end[0]), .busy(busy[0]),
        .parity_bit(parity_bit[0]), .parity_slot(parity_slot[0])
    );

    tdm_frame_sequencer #(.SLOT_CYCLES(SC_B), .IDLE_GAP(GAP_B)) u_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .word_out(word_out[1]), .sel(sel[1]), .slot_valid(slot_valid[1]),
        .frame_start(frame_start[1]), .frame_end(frame_end[1]), .busy(busy[1]),
        .parity_bit(parity_bit[1]), .parity_slot(parity_slot[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sc_of(input int k);
        return (k == 0) ? SC_A : SC_B;
    endfunction

    function automatic int gap_of(input int k);
        return (k == 0) ? GAP_A : GAP_B;
    endfunction

    // Reference frame: slot index = cycle / SLOT_CYCLES, sel saturates at 7, gap cycles follow the slots.
    task automatic push_frame(input int k, input logic [7:0] w);
        int   nslots;
        int   nlive;
        int   slot;
        exp_t e;
        nslots = 8 + PAR;
        nlive  = nslots * sc_of(k);
        for (int i = 0; i < nlive + gap_of(k); i++) begin
            slot   = i / sc_of(k);
            e.sv   = (i < nlive);
            e.sel  = (slot > 7) ? 3'd7 : 3'(slot);
            e.word = w;
            e.fs   = (i == 0);
            e.fe   = (i == nlive - 1);
            e.ps   = (PAR == 1) && (i < nlive) && (slot == 8);
            e.pb   = (PAR == 1) ? ^w : 1'b0;
            sb[k].push_back(e);
        end
        last_word[k] = w;
        last_sel[k]  = 3'd7;
        last_pb[k]   = (PAR == 1) ? ^w : 1'b0;
    endtask

    // Accept observer: a word is taken when valid is high and the model says the block was idle this cycle.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int k = 0; k < 2; k++) begin
                    last_word[k] = 8'd0;
                    last_sel[k]  = 3'd0;
                    last_pb[k]   = 1'b0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (in_valid && exp_ready[k]) push_frame(k, in_data);
                end
            end
        end
    end

    // Monitor: one scoreboard entry per busy cycle; an empty scoreboard means the block must be idle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    sb[k].delete();
                    exp_ready[k] = 1'b1;
                    check($sformatf("u%0d.rst_in_ready", k), in_ready[k], 1'b1);
                    check($sformatf("u%0d.rst_busy", k), busy[k], 1'b0);
                    check($sformatf("u%0d.rst_sel", k), sel[k], 3'd0);
                    check($sformatf("u%0d.rst_word", k), word_out[k], 8'd0);
                    check($sformatf("u%0d.rst_frame_end", k), frame_end[k], 1'b0);
                end else if (sb[k].size() > 0) begin
                    e = sb[k].pop_front();
                    exp_ready[k] = 1'b0;
                    check($sformatf("u%0d.busy", k), busy[k], 1'b1);
                    check($sformatf("u%0d.in_ready", k), in_ready[k], 1'b0);
                    check($sformatf("u%0d.slot_valid", k), slot_valid[k], e.sv);
                    check($sformatf("u%0d.sel", k), sel[k], e.sel);
                    check($sformatf("u%0d.word_out", k), word_out[k], e.word);
                    check($sformatf("u%0d.frame_start", k), frame_start[k], e.fs);
                    check($sformatf("u%0d.frame_end", k), frame_end[k], e.fe);
                    check($sformatf("u%0d.parity_slot", k), parity_slot[k], e.ps);
                    check($sformatf("u%0d.parity_bit", k), parity_bit[k], e.pb);
                end else begin
                    exp_ready[k] = 1'b1;
                    check($sformatf("u%0d.idle_busy", k), busy[k], 1'b0);
                    check($sformatf("u%0d.idle_in_ready", k), in_ready[k], 1'b1);
                    check($sformatf("u%0d.idle_slot_valid", k), slot_valid[k], 1'b0);
                    check($sformatf("u%0d.idle_strobes", k),
                          {frame_start[k], frame_end[k], parity_slot[k]}, 3'b000);
                    check($sformatf("u%0d.idle_sel", k), sel[k], last_sel[k]);
                    check($sformatf("u%0d.idle_word", k), word_out[k], last_word[k]);
                    check($sformatf("u%0d.idle_parity_bit", k), parity_bit[k], last_pb[k]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        in_valid = 1'b1;
        in_data  = w;
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy[0] || busy[1]) && n < 200) begin
            step(1);
            n++;
        end
        check(name, (n >= 200), 1'b0);
        step(1);
    endtask

    initial begin
        int n;
        step(2);
        rst = 1'b0;
        step(10);

        // Basic frame, then 8'h3C held valid while 8'hA5 frames are still running.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step(1);
        in_data  = 8'h3C;
        step(40);
        in_valid = 1'b0;
        wait_idle("timeout_backpressure");

        send(8'hFF);
        wait_idle("timeout_ff");

        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 8'($urandom);
            step(1);
        end
        in_valid = 1'b0;
        wait_idle("timeout_random");

        // Asynchronous reset while the slow instance is in slot 4.
        send(8'h5A);
        n = 0;
        while (!(slot_valid[1] && sel[1] == 3'd4) && n < 100) begin
            step(1);
            n++;
        end
        check("timeout_sel4", (n >= 100), 1'b0);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d.async_busy", k), busy[k], 1'b0);
            check($sformatf("u%0d.async_in_ready", k), in_ready[k], 1'b1);
            check($sformatf("u%0d.async_sel", k), sel[k], 3'd0);
            check($sformatf("u%0d.async_word", k), word_out[k], 8'd0);
            check($sformatf("u%0d.async_outputs", k),
                  {slot_valid[k], frame_start[k], frame_end[k], parity_slot[k], parity_bit[k]}, 5'd0);
        end
        step(2);
        rst = 1'b0;
        send(8'h01);
        wait_idle("timeout_after_reset");

        send(8'h07);
        wait_idle("timeout_parity_07");
        send(8'h03);
        wait_idle("timeout_parity_03");
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tdm_frame_sequencer.md
Name: tdm_frame_sequencer

Overview:
Sequential front end for the 8:1 multiplex / 1:8 demultiplex pair; turns 8-bit parallel words into a time-division frame of 8 slots.
- Accepts a word over a valid/ready handshake and holds it stable on word_out for the multiplex In.
- Steps sel 0..7, shared by multiplex Sel and demultiplex Y, and emits slot and frame strobes.
- Inserts a programmable idle gap between frames.

Parameters:
SLOT_CYCLES, 1, clock cycles each slot is held; legal range 1..255.
IDLE_GAP, 0, clock cycles in GAP after a frame before returning to IDLE; legal range 0..255.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_data  input  8  parallel word to transmit.
in_valid  input  1  in_data is valid.
in_ready  output  1  sequencer can accept a word this cycle.
word_out  output  8  registered copy of the accepted word; drives multiplex In.
sel  output  3  current slot index; drives multiplex Sel and demultiplex Y.
slot_valid  output  1  sel/word_out describe a live slot.
frame_start  output  1  one-cycle pulse on the first cycle of slot 0.
frame_end  output  1  one-cycle pulse on the last cycle of the frame's final slot.
busy  output  1  high in any state other than IDLE.
parity_bit  output  1  even parity of word_out; see Optional Feature.
parity_slot  output  1  high during the parity slot; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-high, one clock, as already decided):
  - Outputs: state=IDLE, word_out=0, sel=0, slot_valid=0, frame_start=0, frame_end=0, busy=0, in_ready=1, parity_bit=0, parity_slot=0.
  - Reset mid-frame aborts immediately. No frame_end is issued.
  - First accept is possible on the first rising edge after rst deasserts.
- States: IDLE, SLOT, PAR (only with the macro), GAP.
- IDLE:
  - in_ready=1 combinationally from state (IDLE only); in_ready is 0 in every other state.
  - Handshake fires when in_valid & in_ready at a rising edge. On that edge: word_out<=in_data, sel<=0, slot counter<=0, state<=SLOT.
  - in_data is ignored when in_valid is low or the block is not ready.
- SLOT:
  - slot_valid=1. Each slot lasts exactly SLOT_CYCLES cycles, counted by an 8-bit cycle counter.
  - frame_start is 1 only when sel==0 and the cycle counter==0.
  - At the end of a slot with sel<7: sel increments by 1.
  - At the end of slot 7: sel stays 7 and frame_end=1 for that last cycle.
  - Next state after slot 7: PAR if compiled in, else GAP if IDLE_GAP>0, else IDLE.
  - sel never wraps inside a frame. sel returns to 0 only on the next accept or on reset.
- GAP:
  - slot_valid=0. Lasts exactly IDLE_GAP cycles, then IDLE.
  - word_out and sel hold their last values throughout.
- Latency and throughput:
  - Accept edge to first slot_valid cycle: 1 clock.
  - Frame length: 8×SLOT_CYCLES cycles (+SLOT_CYCLES with parity).
  - Accept-to-accept minimum: frame length + IDLE_GAP + 1 (one IDLE cycle is mandatory).
- busy=1 in SLOT/PAR/GAP; busy=0 in IDLE.
- word_out is stable for the whole frame. in_data changes while busy have no effect.
- Counters are unsigned and width-exact. SLOT_CYCLES=1 makes frame_start and frame_end coincide with their slot's single cycle.

Optional Feature:
- Macro: TDM_PARITY_EN.
- Defined:
  - PAR state follows slot 7 and lasts SLOT_CYCLES cycles, with slot_valid=1, parity_slot=1, sel held at 7.
  - parity_bit = XOR of word_out bits, registered at accept.
  - frame_end moves to the last cycle of PAR and is not asserted in slot 7.
- Undefined:
  - PAR does not exist; parity_bit and parity_slot are tied to 0.
  - Frame is exactly 8 slots.

Test Plan:
- Reset then idle: rst pulse, in_valid=0 for 10 cycles -> in_ready=1, busy=0, sel=0, slot_valid=0 throughout.
- Basic frame (SLOT_CYCLES=1, IDLE_GAP=0): accept 8'hA5 at cycle 0 ->
  - cycles 1..8: sel=0..7, word_out=8'hA5;
  - frame_start at cycle 1, frame_end at cycle 8;
  - in_ready=1 again at cycle 9.
- Backpressure: in_valid held with 8'h3C during a frame carrying 8'hA5 -> word_out stays 8'hA5 all frame; 8'h3C is accepted only in the next IDLE cycle.
- Stretched slots and gap (SLOT_CYCLES=3, IDLE_GAP=2): accept 8'hFF -> each sel value held 3 cycles, 24 slot_valid cycles, then 2 GAP cycles, then in_ready=1.
- Reset mid-frame: assert rst while sel=4 -> outputs reach reset values asynchronously with no frame_end; a new word 8'h01 is accepted normally afterwards.
- Parity (TDM_PARITY_EN): accept 8'h07 -> 9 slots, parity_slot=1 on slot 9 with parity_bit=1, frame_end only on slot 9. Accept 8'h03 -> parity_bit=0.
